// File: rtl/mult_div_if.sv
// Handshake and result bundle between the control unit (master) and the
// iterative multiply/divide sequencer (slave).
interface mult_div_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             mult_done;
   logic             div_done;
   logic             div_zero;

   modport master (
      output start, op, a, b,
      input  hi, lo, busy, mult_done, div_done, div_zero
   );

   modport slave (
      input  start, op, a, b,
      output hi, lo, busy, mult_done, div_done, div_zero
   );
endinterface

// File: rtl/mult_div_sequencer.sv
// Iterative signed multiply / restoring divide engine: WIDTH iterations on
// operand magnitudes, then a sign-fix step that writes HI/LO.
module mult_div_sequencer #(
   parameter int WIDTH = 32
) (
   input logic        clk,
   input logic        reset,
   mult_div_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t             state_reg;
   logic               start_prev_reg;
   logic               op_reg;
   logic               sign_a_reg;
   logic               sign_b_reg;
   logic [WIDTH-1:0]   a_mag_reg;
   logic [WIDTH-1:0]   b_mag_reg;
   logic [2*WIDTH-1:0] acc_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [WIDTH-1:0]   hi_reg;
   logic [WIDTH-1:0]   lo_reg;
   logic               busy_reg;
   logic               mult_done_reg;
   logic               div_done_reg;
   logic               div_zero_reg;

   logic [WIDTH-1:0]   a_abs;
   logic [WIDTH-1:0]   b_abs;
   logic               accept;
   logic [WIDTH:0]     mult_sum;
   logic [2*WIDTH-1:0] mult_step;
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH-1:0]   rem_diff;
   logic               rem_ge;
   logic [WIDTH-1:0]   rem_next;
   logic [2*WIDTH-1:0] div_step;
   logic [2*WIDTH-1:0] prod_neg;
   logic [WIDTH-1:0]   quo_neg;
   logic [WIDTH-1:0]   rem_neg;

   // The most negative value negates to itself, which is its correct
   // unsigned magnitude.
   assign a_abs  = bus.a[WIDTH-1] ? -bus.a : bus.a;
   assign b_abs  = bus.b[WIDTH-1] ? -bus.b : bus.b;
   assign accept = bus.start && !start_prev_reg;

   always_comb begin
      // Multiply: acc = {partial product, remaining multiplier bits}; the
      // carry out of the add becomes the top bit after the right shift.
      mult_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                + {1'b0, (acc_reg[0] ? a_mag_reg : {WIDTH{1'b0}})};
      mult_step = {mult_sum, acc_reg[WIDTH-1:1]};

      // Divide: acc = {partial remainder, dividend bits / quotient bits}.
      // When rem_shift >= divisor the difference is below the divisor, so
      // the low WIDTH bits of the subtraction are exact.
      rem_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
      rem_ge    = rem_shift >= {1'b0, b_mag_reg};
      rem_diff  = rem_shift[WIDTH-1:0] - b_mag_reg;
      rem_next  = rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
      div_step  = {rem_next, acc_reg[WIDTH-2:0], rem_ge};

      prod_neg  = -acc_reg;
      quo_neg   = -acc_reg[WIDTH-1:0];
      rem_neg   = -acc_reg[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         start_prev_reg <= 1'b1;
         op_reg         <= 1'b0;
         sign_a_reg     <= 1'b0;
         sign_b_reg     <= 1'b0;
         a_mag_reg      <= '0;
         b_mag_reg      <= '0;
         acc_reg        <= '0;
         cnt_reg        <= '0;
         hi_reg         <= '0;
         lo_reg         <= '0;
         busy_reg       <= 1'b0;
         mult_done_reg  <= 1'b0;
         div_done_reg   <= 1'b0;
         div_zero_reg   <= 1'b0;
      end else begin
         start_prev_reg <= bus.start;
         mult_done_reg  <= 1'b0;
         div_done_reg   <= 1'b0;
         div_zero_reg   <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  op_reg     <= bus.op;
                  sign_a_reg <= bus.a[WIDTH-1];
                  sign_b_reg <= bus.b[WIDTH-1];
                  a_mag_reg  <= a_abs;
                  b_mag_reg  <= b_abs;
                  cnt_reg    <= '0;
                  busy_reg   <= 1'b1;
                  acc_reg    <= {{WIDTH{1'b0}}, (bus.op ? a_abs : b_abs)};
                  if (bus.op && (bus.b == '0)) begin
                     state_reg    <= DONE;
                     div_done_reg <= 1'b1;
                     div_zero_reg <= 1'b1;
                  end else begin
                     state_reg <= RUN;
                  end
               end
            end
            RUN: begin
               acc_reg <= op_reg ? div_step : mult_step;
               cnt_reg <= cnt_reg + 1'b1;
               if (cnt_reg == LAST) begin
                  state_reg <= FIX;
               end
            end
            FIX: begin
               if (op_reg) begin
                  lo_reg       <= (sign_a_reg ^ sign_b_reg) ? quo_neg
                                                            : acc_reg[WIDTH-1:0];
                  hi_reg       <= sign_a_reg ? rem_neg : acc_reg[2*WIDTH-1:WIDTH];
                  div_done_reg <= 1'b1;
               end else begin
                  {hi_reg, lo_reg} <= (sign_a_reg ^ sign_b_reg) ? prod_neg : acc_reg;
                  mult_done_reg    <= 1'b1;
               end
               state_reg <= DONE;
            end
            DONE: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.hi        = hi_reg;
   assign bus.lo        = lo_reg;
   assign bus.busy      = busy_reg;
   assign bus.mult_done = mult_done_reg;
   assign bus.div_done  = div_done_reg;
   assign bus.div_zero  = div_zero_reg;
endmodule

// File: doc/mult_div_sequencer.md
Name: mult_div_sequencer

Overview:
- Iterative signed multiply/divide engine for the multicycle CPU.
- Driven by the control unit's Start_mult_div level; reports completion on mult_done / div_done, which the control unit uses to write HI and LO.
- Sequences 32 shift-add multiply iterations or 32 restoring-divide iterations, applies sign correction, and holds HI/LO results until the next operation.
- Flags divide-by-zero so the datapath can raise exception_detected.

Parameters:
- WIDTH, 32, operand width; results are 2*WIDTH split into hi/lo; iteration count = WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  level request from control unit (Start_mult_div)
- op  in  1  0 = mult, 1 = div; sampled only on accept
- a  in  WIDTH  rs operand (multiplicand / dividend); sampled only on accept
- b  in  WIDTH  rt operand (multiplier / divisor); sampled only on accept
- hi  out  WIDTH  mult: upper product word; div: remainder
- lo  out  WIDTH  mult: lower product word; div: quotient
- busy  out  1  high in every state except IDLE
- mult_done  out  1  one-cycle pulse, mult result valid
- div_done  out  1  one-cycle pulse, div result valid (also on divide-by-zero)
- div_zero  out  1  high together with div_done when b == 0; otherwise 0

Behaviour:
- Reset (synchronous, active-high) has priority over all other activity, including an operation in progress:
  - state = IDLE
  - hi = lo = 0; busy, mult_done, div_done, div_zero = 0
  - start-history register = 1, so a start held high through reset is not accepted.
- Accept rule:
  - In IDLE, the op is accepted at an edge where start = 1 and start was 0 at the previous edge (rising-edge detect).
  - A level held high after done does not retrigger; start is ignored outside IDLE.
- On accept (edge E0):
  - Latch op, |a|, |b|, sign(a), sign(b); counter = 0.
  - If op = div and b == 0: go to DONE with div_zero set.
  - Otherwise go to RUN.
- RUN, one iteration per edge E1..E32:
  - mult: unsigned shift-add on the 2*WIDTH accumulator.
  - div: restoring shift-subtract, producing quotient bit and partial remainder.
  - Counter increments each edge; when counter == WIDTH-1, next state = FIX.
- FIX (edge E33):
  - mult: {hi,lo} = sign(a)^sign(b) ? -product : product, as a 64-bit two's complement result.
  - div: lo = sign(a)^sign(b) ? -q : q; hi = sign(a) ? -r : r (remainder takes the dividend's sign).
  - Next state = DONE.
- DONE (exactly one cycle): mult_done or div_done = 1 according to the latched op; next state = IDLE.
- Latency:
  - Done pulse occupies the cycle after E33, i.e. 34 cycles after the accepting edge.
  - Divide-by-zero: done pulse occupies the cycle after E0.
- hi/lo update only at FIX; they hold their value in IDLE, RUN and DONE, and are unchanged on divide-by-zero.
- Overflow case -2^31 / -1: lo = 0x80000000, hi = 0; no flag.
- Most-negative operand: |0x80000000| = 0x80000000 unsigned, which is handled correctly.
- busy = 1 from the cycle after E0 through the DONE cycle.

Test Plan:
- Multiply 7 × 6: mult, a=7, b=6, start rises → mult_done pulses 34 cycles after accept; hi=0x00000000, lo=0x0000002A; start held high afterwards causes no second busy.
- Signed multiply, two cases:
  - mult, a=0xFFFFFFFD (-3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - mult, a=b=0x80000000 → hi=0x40000000, lo=0x00000000.
- Divide 7 / 2 and -7 / 2:
  - div, a=7, b=2 → div_done, lo=3, hi=1, div_zero=0.
  - div, a=0xFFFFFFF9, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide by zero: preload hi/lo via 7/2, then div, a=5, b=0 → div_done and div_zero high in the cycle after accept; hi=1, lo=3 unchanged; busy low the next cycle.
- Overflow and reset mid-op:
  - div, a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
  - Start a mult, assert reset at iteration 10 → next cycle busy=0, hi=lo=0, no done pulse.
  - A fresh start rising edge then completes normally.
